// File: rtl/nbj_pc_sequencer_if.sv
// rtl/nbj_pc_sequencer_if.sv - fetch/backend/next-PC handshake bundle for nbj_pc_sequencer
// Purpose: groups the front descriptor, backend response and next-PC channels.
// Ports (all logic, no interface ports):
//   front : i_frontValid, o_frontReady, i_currentPc_32, i_validSize_5,
//           i_firstJTableEntry_8, i_jumpTarget_32
//   back  : i_backValid, o_backReady, i_type, i_correctPc_32, i_correctPcIndex_3
//   pc    : o_pcValid, i_pcReady, o_nextPc_32, o_cutPosition_8, o_clear
// Modports: slave = sequencer side, master = fetch/backend side.
interface nbj_pc_sequencer_if;
    logic        i_frontValid;
    logic        o_frontReady;
    logic [31:0] i_currentPc_32;
    logic [4:0]  i_validSize_5;
    logic [7:0]  i_firstJTableEntry_8;
    logic [31:0] i_jumpTarget_32;

    logic        i_backValid;
    logic        o_backReady;
    logic        i_type;
    logic [31:0] i_correctPc_32;
    logic [2:0]  i_correctPcIndex_3;

    logic        o_pcValid;
    logic        i_pcReady;
    logic [31:0] o_nextPc_32;
    logic [7:0]  o_cutPosition_8;
    logic        o_clear;

    modport slave (
        input  i_frontValid, i_currentPc_32, i_validSize_5, i_firstJTableEntry_8,
               i_jumpTarget_32, i_backValid, i_type, i_correctPc_32,
               i_correctPcIndex_3, i_pcReady,
        output o_frontReady, o_backReady, o_pcValid, o_nextPc_32,
               o_cutPosition_8, o_clear
    );

    modport master (
        output i_frontValid, i_currentPc_32, i_validSize_5, i_firstJTableEntry_8,
               i_jumpTarget_32, i_backValid, i_type, i_correctPc_32,
               i_correctPcIndex_3, i_pcReady,
        input  o_frontReady, o_backReady, o_pcValid, o_nextPc_32,
               o_cutPosition_8, o_clear
    );
endinterface

// File: rtl/nbj_pc_sequencer.sv
// rtl/nbj_pc_sequencer.sv - next-PC scheduler for the fetch stage with in-flight credit limit
// Purpose: picks the next fetch PC from backend redirect, predicted-taken jump
//   or sequential fall-through; drives next PC, cut mask and clear pulse.
// Ports:
//   clk              in  clock, rising edge
//   rst              in  synchronous active-low reset
//   bus              nbj_pc_sequencer_if.slave (front/back/next-PC channels)
//   o_redirectCnt_16 out saturating redirect counter (only with NBJ_PERF_CNT_EN)
// Configuration macro: NBJ_PERF_CNT_EN
module nbj_pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          MAX_INFLIGHT = 4,
    parameter int          FLUSH_CYC    = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef NBJ_PERF_CNT_EN
    output logic [15:0]        o_redirectCnt_16,
`endif
    nbj_pc_sequencer_if.slave  bus
);
    localparam logic [3:0] MAX_C   = 4'(MAX_INFLIGHT);
    localparam logic [2:0] FLUSH_C = 3'(FLUSH_CYC);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        pc_valid_q, pc_valid_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [7:0]  cut_q, cut_d;
    logic        clear_q, clear_d;
    logic [3:0]  credits_q, credits_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        back_ready_q;

    logic        redirect;
    logic        ack;
    logic        out_hs;
    logic        slot_free;
    logic        front_ready;
    logic        front_fire;
    logic [7:0]  jump_cut;
    logic [7:0]  seq_cut;
    logic [7:0]  redir_cut;
    logic [31:0] seq_pc;

    // Redirects are ignored in BOOT: the reset PC has not been issued yet.
    assign redirect  = bus.i_backValid & bus.i_type & (state_q != ST_BOOT);
    assign ack       = bus.i_backValid & ~bus.i_type;
    assign out_hs    = pc_valid_q & bus.i_pcReady;
    assign slot_free = ~pc_valid_q | bus.i_pcReady;

    assign front_ready = rst & (state_q == ST_RUN) & slot_free
                       & (credits_q < MAX_C) & ~redirect;
    assign front_fire  = front_ready & bus.i_frontValid;

    // x ^ (x-1) keeps everything up to and including the lowest set bit.
    assign jump_cut = bus.i_firstJTableEntry_8 ^ (bus.i_firstJTableEntry_8 - 8'd1);
    assign seq_pc   = bus.i_currentPc_32 + {25'd0, bus.i_validSize_5, 2'b00};

    always_comb begin
        seq_cut   = '0;
        redir_cut = '0;
        for (int i = 0; i < 8; i++) begin
            seq_cut[i]   = (bus.i_validSize_5 > 5'(i));
            redir_cut[i] = (bus.i_correctPcIndex_3 >= 3'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_valid_d  = pc_valid_q;
        next_pc_d   = next_pc_q;
        cut_d       = cut_q;
        clear_d     = 1'b0;
        credits_d   = credits_q;
        flush_cnt_d = flush_cnt_q;

        if (state_q == ST_BOOT) begin
            state_d    = ST_RUN;
            pc_valid_d = 1'b1;
            next_pc_d  = RESET_PC;
            cut_d      = 8'hFF;
        end else if (redirect) begin
            // Overwrites any pending PC; o_clear tells fetch it happened.
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_C;
            pc_valid_d  = 1'b1;
            next_pc_d   = bus.i_correctPc_32;
            cut_d       = redir_cut;
            clear_d     = 1'b1;
            credits_d   = '0;
        end else begin
            // Ack at zero credits is dropped; +1 and -1 together cancel.
            if (out_hs && !(ack && credits_q != '0)) begin
                credits_d = credits_q + 4'd1;
            end else if (!out_hs && ack && credits_q != '0) begin
                credits_d = credits_q - 4'd1;
            end

            if (front_fire) begin
                pc_valid_d = 1'b1;
                if (bus.i_firstJTableEntry_8 != '0) begin
                    next_pc_d = bus.i_jumpTarget_32;
                    cut_d     = jump_cut;
                end else begin
                    next_pc_d = seq_pc;
                    cut_d     = seq_cut;
                end
            end else if (out_hs) begin
                pc_valid_d = 1'b0;
            end

            if (state_q == ST_FLUSH) begin
                if (flush_cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                end
                flush_cnt_d = flush_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            pc_valid_q   <= 1'b0;
            next_pc_q    <= RESET_PC;
            cut_q        <= '0;
            clear_q      <= 1'b0;
            credits_q    <= '0;
            flush_cnt_q  <= '0;
            back_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_valid_q   <= pc_valid_d;
            next_pc_q    <= next_pc_d;
            cut_q        <= cut_d;
            clear_q      <= clear_d;
            credits_q    <= credits_d;
            flush_cnt_q  <= flush_cnt_d;
            back_ready_q <= 1'b1;
        end
    end

`ifdef NBJ_PERF_CNT_EN
    logic [15:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_cnt_q <= '0;
        end else if (redirect && redirect_cnt_q != 16'hFFFF) begin
            redirect_cnt_q <= redirect_cnt_q + 16'd1;
        end
    end

    assign o_redirectCnt_16 = redirect_cnt_q;
`endif

    assign bus.o_frontReady    = front_ready;
    assign bus.o_backReady     = back_ready_q;
    assign bus.o_pcValid       = pc_valid_q;
    assign bus.o_nextPc_32     = next_pc_q;
    assign bus.o_cutPosition_8 = cut_q;
    assign bus.o_clear         = clear_q;
endmodule
